acc_flag_unit: RTL

Downstream consumer of the 16-bit add/sub ALU in the accumulator datapath.
- Registers the ALU result into the accumulator (ACC).
- Latches the ALU zero and sign indicators into a flags register.
- Evaluates branch conditions from the latched flags.
- Drives a valid/ready store port that writes ACC to data memory.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/acc_store_port.sv | 58 +++++
 rtl/acc_flag_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the accumulator datapath: ACC source select, branch
// condition codes, store-port FSM states, and the branch-condition evaluator.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_IMM  = 2'd3
  } acc_src_t;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'd0,
    BR_BNE    = 3'd1,
    BR_BGT    = 3'd2,
    BR_BGE    = 3'd3,
    BR_BLT    = 3'd4,
    BR_BLE    = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_NEVER  = 3'd7
  } branch_cond_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } store_state_t;

  // Evaluate a branch condition against latched zero/negative flags.
  function automatic logic branch_cond_met(branch_cond_t cond, logic z, logic n);
    logic met;
    met = 1'b0;
    case (cond)
      BR_BEQ:    met = z;
      BR_BNE:    met = ~z;
      BR_BGT:    met = ~z & ~n;
      BR_BGE:    met = ~n;
      BR_BLT:    met = n;
      BR_BLE:    met = n | z;
      BR_ALWAYS: met = 1'b1;
      BR_NEVER:  met = 1'b0;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/acc_store_port.sv
// Valid/ready store port: captures ACC on request, presents it to data
// memory until accepted, then emits a one-cycle completion pulse.
module acc_store_port
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done
);

  store_state_t state;

  // Store FSM with registered valid/busy/done and held capture data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets a capture see the old ACC
  // even when ACC is written at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // ready is ignored here; only a request starts a transfer
          if (req) begin
            data  <= acc;
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= ST_VALID;
          end
        end
        ST_VALID: begin
          // requests arriving while busy are dropped, not queued
          if (ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acc_flag_unit.sv
// Accumulator, Z/N flag latch, branch evaluator and store port sitting
// downstream of the 16-bit add/sub ALU.
module acc_flag_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic [DATA_WIDTH-1:0] alu_in,
  input  logic                  zero_indicator_in,
  input  logic                  signal_bit_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] imm_in,
  input  logic [1:0]            acc_src_in,
  input  logic                  acc_write_in,
  input  logic                  flags_write_in,
  input  logic                  branch_check_in,
  input  logic [2:0]            branch_cond_in,
  output logic                  branch_taken_out,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic                  zero_flag_out,
  output logic                  signal_flag_out,
  input  logic                  store_req_in,
  output logic                  store_valid_out,
  output logic [DATA_WIDTH-1:0] store_data_out,
  input  logic                  store_ready_in,
  output logic                  store_busy_out,
  output logic                  store_done_out
);

  logic [DATA_WIDTH-1:0] acc_next;
  logic                  acc_load;
  logic                  cond_met;

  // Select the next ACC value; HOLD or a disabled write keeps the current one.
  // NOTE: acc_next and acc_load get defaults first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_next = acc_out;
    acc_load = acc_write_in;
    case (acc_src_t'(acc_src_in))
      SRC_ALU:  acc_next = alu_in;
      SRC_MEM:  acc_next = mem_data_in;
      SRC_IMM:  acc_next = imm_in;
      default:  acc_load = 1'b0;
    endcase
  end

  // Branch condition from the currently latched flags (pre-edge values).
  always_comb begin
    cond_met = branch_cond_met(branch_cond_t'(branch_cond_in),
                               zero_flag_out, signal_flag_out);
  end

  // ACC, flags and the one-cycle branch decision pulse.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      acc_out          <= '0;
      zero_flag_out    <= 1'b0;
      signal_flag_out  <= 1'b0;
      branch_taken_out <= 1'b0;
    end else begin
      if (acc_load) begin
        acc_out <= acc_next;
      end
      if (flags_write_in) begin
        zero_flag_out   <= zero_indicator_in;
        signal_flag_out <= signal_bit_in;
      end
      branch_taken_out <= branch_check_in & cond_met;
    end
  end

  acc_store_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store_port (
    .clk   (clock_in),
    .rst_n (reset_n_in),
    .req   (store_req_in),
    .ready (store_ready_in),
    .acc   (acc_out),
    .valid (store_valid_out),
    .data  (store_data_out),
    .busy  (store_busy_out),
    .done  (store_done_out)
  );

endmodule
